// File: rtl/sram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_pkg
//   Shared definitions for the SRAM-backed FIFO controller.
//   - Default parameter constants for address width, word width and depth.
//   - ptr_inc(): pointer increment that wraps at an arbitrary depth, so the
//     FIFO can use a RAM depth that is not a power of two.
// -----------------------------------------------------------------------------
package sram_fifo_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 256;

   // Next value of a circular pointer running over 0..depth-1.
   function automatic int unsigned ptr_inc(input int unsigned ptr,
                                           input int unsigned depth);
      if (ptr >= depth - 1)
         return 0;
      else
         return ptr + 1;
   endfunction

endpackage

// File: rtl/sram_fifo_ptr.sv
// -----------------------------------------------------------------------------
// sram_fifo_ptr
//   Circular RAM pointer: counts 0..DEPTH-1 and wraps to 0, advancing only
//   when en is high. Used for both the write and the read pointer.
//
// Ports
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset, pointer returns to 0
//   en   in   advance the pointer this cycle
//   ptr  out  current pointer value (ADDR_WIDTH bits)
// -----------------------------------------------------------------------------
module sram_fifo_ptr
   import sram_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] ptr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (en)
         ptr <= ADDR_WIDTH'(ptr_inc(32'(ptr), DEPTH));
   end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Turns a single-port synchronous RAM (one access per cycle, read data
//   available the cycle after the read) into a FIFO with valid/ready
//   streaming ports. A one-entry output register hides the RAM read latency
//   from the consumer. Reads win over writes when both could happen.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset; discards all contents
//   in_valid   in   producer has a word
//   in_ready   out  word on in_data is accepted this cycle
//   in_data    in   producer word
//   out_valid  out  output register holds a word
//   out_ready  in   consumer takes the word this cycle
//   out_data   out  output register contents (stable while held)
//   fill       out  words currently held in the RAM (not counting the
//                   read in flight or the output register)
//   ram_write  out  RAM write strobe
//   ram_addr   out  RAM address (read pointer on a read, else write pointer)
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   fill,
   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam logic [ADDR_WIDTH:0] FILL_FULL = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_pend;
   logic                  rd_issue;
   logic                  wr_fire;

   // Access decode. Everything here depends on registered state (plus rst and
   // in_valid/in_data for the write strobe), never on out_ready, so there is
   // no combinational path from the consumer back into the producer side.
   // A read is only issued when the output register is empty and no read is
   // already in flight, which guarantees the captured word always has a free
   // slot to land in.
   always_comb begin
      rd_issue  = 1'b0;
      in_ready  = 1'b0;
      wr_fire   = 1'b0;
      ram_addr  = '0;
      ram_wdata = in_data;

      rd_issue = (fill != '0) && !out_valid && !rd_pend;
      // Reads take the RAM port, so the producer is stalled on read cycles.
      in_ready = !rst && (fill != FILL_FULL) && !rd_issue;
      wr_fire  = in_valid && in_ready;

      if (rst)
         ram_addr = '0;
      else if (rd_issue)
         ram_addr = rd_ptr;
      else
         ram_addr = wr_ptr;
   end

   assign ram_write = wr_fire;

   sram_fifo_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .en  (wr_fire),
      .ptr (wr_ptr)
   );

   sram_fifo_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .en  (rd_issue),
      .ptr (rd_ptr)
   );

   // RAM occupancy. A write and a read are mutually exclusive (in_ready is
   // low whenever a read is issued), so at most one of these branches fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fill <= '0;
      else if (wr_fire)
         fill <= fill + 1'b1;
      else if (rd_issue)
         fill <= fill - 1'b1;
   end

   // Read pipeline: read issued -> rd_pend (RAM data on ram_rdata) -> output
   // register. Capture and consumer pop never coincide: a capture needs
   // rd_pend, which needs out_valid to have been low when the read issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_pend) begin
            out_data  <= ram_rdata;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//   Two controllers (DEPTH=4 and DEPTH=3, both with 3 address bits) each
//   attached to a behavioural single-port RAM. A queue-based model predicts
//   every output on every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

   localparam int AW = 3;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]         in_valid  = '0;
   logic [1:0]         out_ready = '0;
   logic [1:0][DW-1:0] in_data   = '0;
   logic [1:0][DW-1:0] ram_rdata;

   wire  [1:0]         in_ready;
   wire  [1:0]         out_valid;
   wire  [1:0]         ram_write;
   wire  [1:0][DW-1:0] out_data;
   wire  [1:0][DW-1:0] ram_wdata;
   wire  [1:0][AW:0]   fill;
   wire  [1:0][AW-1:0] ram_addr;

   sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .fill(fill[0]), .ram_write(ram_write[0]), .ram_addr(ram_addr[0]),
      .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
   );

   sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .fill(fill[1]), .ram_write(ram_write[1]), .ram_addr(ram_addr[1]),
      .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
   );

   // Single-port synchronous RAMs, registered read data.
   logic [DW-1:0] mem0 [8];
   logic [DW-1:0] mem1 [8];
   always @(posedge clk) begin
      if (ram_write[0]) mem0[ram_addr[0]] <= ram_wdata[0];
      ram_rdata[0] <= mem0[ram_addr[0]];
      if (ram_write[1]) mem1[ram_addr[1]] <= ram_wdata[1];
      ram_rdata[1] <= mem1[ram_addr[1]];
   end

   // ---------------- behavioural model ----------------
   logic [DW-1:0]      mq0 [$];
   logic [DW-1:0]      mq1 [$];
   int                 mwr [2];     // words written since reset
   int                 mrd [2];     // reads issued since reset
   bit                 mpend [2];
   bit                 mov [2];
   logic [1:0][DW-1:0] mpw;
   logic [1:0][DW-1:0] mout;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic int dep(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic int q_size(input int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic bit m_rdi(input int i);
      return (q_size(i) != 0) && !mov[i] && !mpend[i];
   endfunction

   function automatic bit m_inr(input int i);
      return !rst && (q_size(i) != dep(i)) && !m_rdi(i);
   endfunction

   initial begin : model
      bit ri, wf;
      for (int i = 0; i < 2; i++) begin
         mwr[i] = 0; mrd[i] = 0; mpend[i] = 0; mov[i] = 0;
      end
      mpw = '0; mout = '0;
      forever begin
         @(posedge clk or posedge rst);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               if (i == 0) mq0.delete(); else mq1.delete();
               mwr[i] = 0; mrd[i] = 0; mpend[i] = 0; mov[i] = 0;
               mout[i] = '0;
            end else begin
               ri = m_rdi(i);
               wf = in_valid[i] && m_inr(i);
               if (mov[i] && out_ready[i]) mov[i] = 0;
               if (mpend[i]) begin
                  mov[i]   = 1;
                  mout[i]  = mpw[i];
                  mpend[i] = 0;
               end
               if (ri) begin
                  mpw[i]   = (i == 0) ? mq0.pop_front() : mq1.pop_front();
                  mpend[i] = 1;
                  mrd[i]++;
               end
               if (wf) begin
                  if (i == 0) mq0.push_back(in_data[i]); else mq1.push_back(in_data[i]);
                  mwr[i]++;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (DEPTH=%0d) t=%0t: got 0x%0h, expected 0x%0h",
                  nm, dep(i), $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   bit [1:0]           prev_hold = '0;
   logic [1:0][DW-1:0] prev_data = '0;

   task automatic check_inst(input int i);
      bit rdi, inr, wr;
      int addr;
      rdi  = m_rdi(i);
      inr  = m_inr(i);
      wr   = in_valid[i] && inr;
      addr = rst ? 0 : (rdi ? mrd[i] % dep(i) : mwr[i] % dep(i));
      chk("in_ready",  i, 32'(in_ready[i]),  32'(inr));
      chk("ram_write", i, 32'(ram_write[i]), 32'(wr));
      chk("ram_addr",  i, 32'(ram_addr[i]),  addr);
      chk("fill",      i, 32'(fill[i]),      q_size(i));
      chk("out_valid", i, 32'(out_valid[i]), 32'(mov[i]));
      if (mov[i]) chk("out_data", i, 32'(out_data[i]), 32'(mout[i]));
      if (wr)     chk("ram_wdata", i, 32'(ram_wdata[i]), 32'(in_data[i]));
      if (!rst && prev_hold[i])
         chk("out_data_stable", i, 32'(out_data[i]), 32'(prev_data[i]));
      prev_hold[i] = !rst && out_valid[i] && !out_ready[i];
      prev_data[i] = out_data[i];
   endtask

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_inst(i);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int  nacc [2];
   int  nout [2];
   int  nw;
   bit  got [2];
   bit  acc [2];

   initial begin
      tick();
      tick();
      rst = 1'b0;

      // Single word through an empty FIFO.
      in_valid = 2'b11; in_data[0] = 8'hA5; in_data[1] = 8'hA5; out_ready = '0;
      @(negedge clk);
      chk("t1_write_c0", 0, 32'(ram_write[0]), 1);
      chk("t1_addr_c0",  0, 32'(ram_addr[0]),  0);
      chk("t1_fill_c0",  0, 32'(fill[0]),      0);
      tick(); in_valid = '0;
      @(negedge clk);
      chk("t1_fill_c1",  0, 32'(fill[0]),      1);
      chk("t1_write_c1", 0, 32'(ram_write[0]), 0);
      tick();
      @(negedge clk);
      chk("t1_fill_c2",  0, 32'(fill[0]),      0);
      chk("t1_ovalid_c2",0, 32'(out_valid[0]), 0);
      tick();
      @(negedge clk);
      chk("t1_ovalid_c3",0, 32'(out_valid[0]), 1);
      chk("t1_odata_c3", 0, 32'(out_data[0]),  32'h A5);
      tick();

      // Fill up with the consumer stalled.
      do_reset();
      nacc[0] = 0; nacc[1] = 0;
      in_valid = 2'b11; in_data[0] = 8'h01; in_data[1] = 8'h01;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) acc[i] = in_valid[i] && in_ready[i];
         tick();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) nacc[i]++;
            in_valid[i] = (nacc[i] < 7);
            in_data[i]  = 8'(nacc[i] + 1);
         end
      end
      @(negedge clk);
      chk("t2_accepted", 0, nacc[0], 5);
      chk("t2_accepted", 1, nacc[1], 4);
      for (int i = 0; i < 2; i++) begin
         chk("t2_in_ready", i, 32'(in_ready[i]), 0);
         chk("t2_fill",     i, 32'(fill[i]),     dep(i));
         chk("t2_out_data", i, 32'(out_data[i]), 1);
      end
      tick();

      // Reset in the middle of a read: pop once, then the refill read issues.
      in_valid = '0; out_ready = 2'b11; tick();
      out_ready = '0; tick();
      chk("t5_model_fill", 0, q_size(0), 3);
      chk("t5_model_pend", 0, 32'(mpend[0]), 1);
      in_valid = 2'b11; in_data[0] = 8'h77; in_data[1] = 8'h77;
      #2;
      chk("t5_write_before", 0, 32'(ram_write[0]), 1);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("t5_out_valid", i, 32'(out_valid[i]), 0);
         chk("t5_fill",      i, 32'(fill[i]),      0);
         chk("t5_ram_write", i, 32'(ram_write[i]), 0);
         chk("t5_in_ready",  i, 32'(in_ready[i]),  0);
      end
      tick(); tick();
      in_valid = '0;
      rst = 1'b0;
      in_valid = 2'b11; in_data[0] = 8'h3C; in_data[1] = 8'h3C; out_ready = 2'b11;
      got[0] = 0; got[1] = 0;
      repeat (12) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            acc[i] = in_valid[i] && in_ready[i];
            if (out_valid[i] && !got[i]) begin
               chk("t5_first_out", i, 32'(out_data[i]), 32'h3C);
               got[i] = 1;
            end
         end
         tick();
         for (int i = 0; i < 2; i++) if (acc[i]) in_valid[i] = 1'b0;
      end
      for (int i = 0; i < 2; i++) chk("t5_out_seen", i, 32'(got[i]), 1);

      // Wrap-around with write-address sequence on the DEPTH=3 instance.
      do_reset();
      out_ready = 2'b11;
      nacc[0] = 0; nacc[1] = 0; nout[0] = 0; nout[1] = 0; nw = 0;
      in_valid = 2'b11; in_data[0] = 8'h10; in_data[1] = 8'h10;
      for (int c = 0; c < 200 && (nout[0] < 10 || nout[1] < 10); c++) begin
         @(negedge clk);
         if (ram_write[1]) begin
            chk("t3_wr_addr", 1, 32'(ram_addr[1]), nw % 3);
            nw++;
         end
         for (int i = 0; i < 2; i++) begin
            acc[i] = in_valid[i] && in_ready[i];
            if (out_valid[i] && out_ready[i]) begin
               chk("t3_order", i, 32'(out_data[i]), 32'h10 + nout[i]);
               nout[i]++;
            end
         end
         tick();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) nacc[i]++;
            in_valid[i] = (nacc[i] < 10);
            in_data[i]  = 8'(8'h10 + nacc[i]);
         end
      end
      for (int i = 0; i < 2; i++) chk("t3_count", i, nout[i], 10);

      // Back-pressure: consumer ready every other cycle, random producer.
      do_reset();
      for (int c = 0; c < 200; c++) begin
         out_ready = c[0] ? 2'b11 : 2'b00;
         in_valid  = 2'($urandom_range(0, 3));
         in_data   = 16'($urandom);
         tick();
      end

      // Both sides streaming continuously.
      in_valid = 2'b11; out_ready = 2'b11;
      for (int c = 0; c < 150; c++) begin
         in_data = 16'($urandom);
         tick();
      end

      // Fully random traffic.
      for (int c = 0; c < 300; c++) begin
         in_valid  = 2'($urandom_range(0, 3));
         out_ready = 2'($urandom_range(0, 3));
         in_data   = 16'($urandom);
         tick();
      end

      in_valid = '0; out_ready = 2'b11;
      repeat (30) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
